// File: rtl/dsc_request_scheduler_if.sv
// -----------------------------------------------------------------------------
// dsc_request_scheduler_if
// Request channel from the descriptor request scheduler to fpga2cpu.
// The channel is a valid/ready handshake that carries one queue id.
//
// Signals:
//   out_dsc_req_queue_id  queue that needs an extra pkt descriptor
//   out_dsc_req_valid     request valid (held until accepted)
//   out_dsc_req_ready     fpga2cpu accepts the request
//
// Modports:
//   master  the scheduler side (drives id/valid, samples ready)
//   slave   the fpga2cpu side (samples id/valid, drives ready)
// -----------------------------------------------------------------------------
interface dsc_request_scheduler_if #(
    parameter int NB_QUEUES = 512
);
    logic [$clog2(NB_QUEUES)-1:0] out_dsc_req_queue_id;
    logic                         out_dsc_req_valid;
    logic                         out_dsc_req_ready;

    modport master (
        output out_dsc_req_queue_id,
        output out_dsc_req_valid,
        input  out_dsc_req_ready
    );

    modport slave (
        input  out_dsc_req_queue_id,
        input  out_dsc_req_valid,
        output out_dsc_req_ready
    );
endinterface

// File: rtl/dsc_request_scheduler.sv
// -----------------------------------------------------------------------------
// dsc_request_scheduler
// Tracks, for each packet queue, whether software has advanced its head pointer
// without a later pkt descriptor having been sent for that queue. Queues in
// that state hold residue packets that software cannot see. A round-robin
// scanner walks the pending set one word per cycle. It issues one descriptor
// request at a time to fpga2cpu, which then sends a descriptor that carries the
// latest tail.
//
// Parameters:
//   NB_QUEUES  number of pkt queues (power of 2, multiple of WORD_BITS)
//   WORD_BITS  pending bits examined per scan cycle (power of 2)
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   queue_updated         software head pointer write seen this cycle
//   updated_queue_idx     queue whose head was written
//   pkt_dsc_sent          fpga2cpu sent a pkt descriptor this cycle
//   pkt_dsc_queue_idx     queue of that descriptor
//   cfg_enable            1: issue requests, 0: track only
//   pending_any           registered OR of all pending bits (one-cycle lag)
//   req (master)          request channel: queue id / valid / ready
//   stat_req_issued       [DSC_SCHED_STATS_EN] count of accepted requests
//   stat_req_suppressed   [DSC_SCHED_STATS_EN] count of pkt_dsc_sent hits on
//                         an already-pending queue
//
// Optional feature macro: DSC_SCHED_STATS_EN (adds the two statistics counters).
// -----------------------------------------------------------------------------
module dsc_request_scheduler #(
    parameter int NB_QUEUES = 512,
    parameter int WORD_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         queue_updated,
    input  logic [$clog2(NB_QUEUES)-1:0] updated_queue_idx,
    input  logic                         pkt_dsc_sent,
    input  logic [$clog2(NB_QUEUES)-1:0] pkt_dsc_queue_idx,
    input  logic                         cfg_enable,
    output logic                         pending_any,
`ifdef DSC_SCHED_STATS_EN
    output logic [31:0]                  stat_req_issued,
    output logic [31:0]                  stat_req_suppressed,
`endif
    dsc_request_scheduler_if.master      req
);

    localparam int QW   = $clog2(NB_QUEUES);
    localparam int NW   = NB_QUEUES / WORD_BITS;
    localparam int PW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int WB_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Index of the lowest set bit of a scan word. The result is 0 for an
    // all-zero word; callers qualify it with a non-zero test.
    function automatic logic [WB_W-1:0] lowest_set(input logic [WORD_BITS-1:0] w);
        logic [WB_W-1:0] idx;
        idx = '0;
        for (int i = WORD_BITS - 1; i >= 0; i--) begin
            if (w[i]) begin
                idx = WB_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [NB_QUEUES-1:0]   pending_r;
    logic [NB_QUEUES-1:0]   pending_nxt_s;
    logic [PW-1:0]          scan_ptr_r;
    logic [PW-1:0]          scan_ptr_nxt_s;
    logic [PW-1:0]          scan_ptr_inc_s;
    logic                   valid_r;
    logic                   valid_nxt_s;
    logic [QW-1:0]          qid_r;          // held_qid, also drives the id output
    logic [QW-1:0]          qid_nxt_s;
    logic                   pending_any_r;
    logic                   handshake_s;
    logic [QW-1:0]          word_base_s;
    logic [WORD_BITS-1:0]   word_s;
    logic [NB_QUEUES-1:0]   set_mask_s;
    logic [NB_QUEUES-1:0]   dsc_clr_mask_s;
    logic [NB_QUEUES-1:0]   hs_clr_mask_s;

    // Word window addressed by the scan pointer; it reads registered pending
    // state, so bits set this cycle become visible on the next cycle.
    always_comb begin
        word_base_s = QW'(scan_ptr_r) << WB_W;
        word_s      = pending_r[word_base_s +: WORD_BITS];
        if (scan_ptr_r == PW'(NW - 1)) begin
            scan_ptr_inc_s = '0;
        end else begin
            scan_ptr_inc_s = scan_ptr_r + PW'(1);
        end
    end

    // Scheduler next-state and output logic.
    always_comb begin
        state_nxt_s    = state_r;
        scan_ptr_nxt_s = scan_ptr_r;
        valid_nxt_s    = valid_r;
        qid_nxt_s      = qid_r;
        handshake_s    = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if ((word_s != '0) && cfg_enable) begin
                    qid_nxt_s   = word_base_s | QW'(lowest_set(word_s));
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_EMIT;
                end else begin
                    scan_ptr_nxt_s = scan_ptr_inc_s;
                end
            end
            ST_EMIT: begin
                // The request is never retracted: a redundant descriptor is
                // harmless downstream, while a dropped one would strand packets.
                if (valid_r && req.out_dsc_req_ready) begin
                    handshake_s    = 1'b1;
                    valid_nxt_s    = 1'b0;
                    scan_ptr_nxt_s = scan_ptr_inc_s;
                    state_nxt_s    = ST_SCAN;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_SCAN;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Pending set update. Either clear overrides a set of the same queue,
    // because the descriptor about to be sent already carries the latest tail.
    always_comb begin
        set_mask_s     = queue_updated ? (NB_QUEUES'(1) << updated_queue_idx) : '0;
        dsc_clr_mask_s = pkt_dsc_sent  ? (NB_QUEUES'(1) << pkt_dsc_queue_idx) : '0;
        hs_clr_mask_s  = handshake_s   ? (NB_QUEUES'(1) << qid_r)             : '0;
        pending_nxt_s  = (pending_r | set_mask_s) & ~dsc_clr_mask_s & ~hs_clr_mask_s;
    end

    // State, pending set and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_SCAN;
            pending_r     <= '0;
            scan_ptr_r    <= '0;
            valid_r       <= 1'b0;
            qid_r         <= '0;
            pending_any_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pending_r     <= pending_nxt_s;
            scan_ptr_r    <= scan_ptr_nxt_s;
            valid_r       <= valid_nxt_s;
            qid_r         <= qid_nxt_s;
            pending_any_r <= |pending_r;
        end
    end

    assign req.out_dsc_req_valid    = valid_r;
    assign req.out_dsc_req_queue_id = qid_r;
    assign pending_any              = pending_any_r;

`ifdef DSC_SCHED_STATS_EN
    logic [31:0] stat_issued_r;
    logic [31:0] stat_suppressed_r;

    // Statistics counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_r     <= 32'd0;
            stat_suppressed_r <= 32'd0;
        end else begin
            if (handshake_s) begin
                stat_issued_r <= stat_issued_r + 32'd1;
            end else begin
                stat_issued_r <= stat_issued_r;
            end
            if (pkt_dsc_sent && pending_r[pkt_dsc_queue_idx]) begin
                stat_suppressed_r <= stat_suppressed_r + 32'd1;
            end else begin
                stat_suppressed_r <= stat_suppressed_r;
            end
        end
    end

    assign stat_req_issued     = stat_issued_r;
    assign stat_req_suppressed = stat_suppressed_r;
`endif

endmodule
